// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
// The optional MOUSE_SCROLL_EN build uses the same package unchanged.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    APPLY   = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  localparam int DELTA_W = 9;
  localparam int WORK_W  = 11;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One axis: adds a signed delta to an unsigned coordinate in WORK_W-bit
// signed arithmetic and saturates the result to 0..MAX.
module mouse_axis_clamp
  import mouse_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 159,
  parameter int DW    = DELTA_W
) (
  input  logic [WIDTH-1:0]        cur_i,
  input  logic signed [DW-1:0]    delta_i,
  output logic [WIDTH-1:0]        res_o
);

  localparam logic signed [WORK_W-1:0] MAX_W = WORK_W'(MAX);

  logic signed [WORK_W-1:0] sum;

  assign sum = $signed({{(WORK_W-WIDTH){1'b0}}, cur_i})
             + $signed({{(WORK_W-DW){delta_i[DW-1]}}, delta_i});

  always_comb begin
    res_o = sum[WIDTH-1:0];
    if (sum[WORK_W-1]) begin
      res_o = '0;
    end else if (sum > MAX_W) begin
      res_o = MAX_W[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Turns decoded PS/2 packets into clamped absolute cursor coordinates and buttons.
// Define MOUSE_SCROLL_EN to also accumulate the scroll wheel delta into MOUSE_Z.
//
// state   | meaning
// IDLE    | waiting for a packet interrupt
// CALC    | form 9-bit signed deltas, applying overflow saturation
// APPLY   | add deltas, clamp, register outputs and buttons
// PUBLISH | pulse POS_UPDATED; chain to a pending packet if one is held
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int Z_MAX = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic [7:0] MOUSE_DZ,
  input  logic       SEND_INTERRUPT,
  output logic [7:0] MOUSE_X,
  output logic [6:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic [2:0] MOUSE_BUTTONS,
  output logic       POS_UPDATED,
  output logic       BUSY
);

  state_e state_q, state_d;

  logic [7:0] stat_q, dx_q, dy_q;
  logic [7:0] pend_stat_q, pend_dx_q, pend_dy_q;
  logic       pend_q;
  logic signed [DELTA_W-1:0] dx9_q, dx9_d, dy9_d;
  logic signed [DELTA_W:0]   dyn_q, dyn_d;
  logic [7:0] x_q, x_new;
  logic [6:0] y_q, y_new;
  logic [2:0] btn_q;
  logic       upd_q, busy_q;
  logic       load_new, load_pend, hold_pend;
  logic       unused_bits;

  assign load_new  = SEND_INTERRUPT && (state_q == IDLE || state_q == PUBLISH);
  assign load_pend = (state_q == PUBLISH) && !SEND_INTERRUPT && pend_q;
  assign hold_pend = SEND_INTERRUPT && (state_q == CALC || state_q == APPLY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (SEND_INTERRUPT) state_d = CALC;
      CALC:    state_d = APPLY;
      APPLY:   state_d = PUBLISH;
      PUBLISH: state_d = (SEND_INTERRUPT || pend_q) ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Overflow forces full-scale deltas; Y is negated because PS/2 up is screen down.
  always_comb begin
    dx9_d = stat_q[XOVF] ? (stat_q[XSIGN] ? 9'sh100 : 9'sh0FF)
                         : $signed({stat_q[XSIGN], dx_q});
    dy9_d = stat_q[YOVF] ? (stat_q[YSIGN] ? 9'sh100 : 9'sh0FF)
                         : $signed({stat_q[YSIGN], dy_q});
    dyn_d = -{dy9_d[DELTA_W-1], dy9_d};
  end

  mouse_axis_clamp #(.WIDTH(8), .MAX(X_MAX), .DW(DELTA_W)) u_clamp_x (
    .cur_i(x_q), .delta_i(dx9_q), .res_o(x_new)
  );

  mouse_axis_clamp #(.WIDTH(7), .MAX(Y_MAX), .DW(DELTA_W+1)) u_clamp_y (
    .cur_i(y_q), .delta_i(dyn_q), .res_o(y_new)
  );

`ifdef MOUSE_SCROLL_EN
  logic [7:0] dz_q, pend_dz_q, z_q, z_new;
  logic signed [DELTA_W:0] dz10_q;

  mouse_axis_clamp #(.WIDTH(8), .MAX(Z_MAX), .DW(DELTA_W+1)) u_clamp_z (
    .cur_i(z_q), .delta_i(dz10_q), .res_o(z_new)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dz_q      <= '0;
      pend_dz_q <= '0;
      dz10_q    <= '0;
      z_q       <= '0;
    end else begin
      if (load_new)       dz_q <= MOUSE_DZ;
      else if (load_pend) dz_q <= pend_dz_q;
      if (hold_pend)      pend_dz_q <= MOUSE_DZ;
      if (state_q == CALC)  dz10_q <= $signed({{2{dz_q[7]}}, dz_q});
      if (state_q == APPLY) z_q <= z_new;
    end
  end

  assign MOUSE_Z     = z_q;
  assign unused_bits = stat_q[3];
`else
  assign MOUSE_Z     = '0;
  assign unused_bits = ^{stat_q[3], MOUSE_DZ, 8'(Z_MAX)};
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      stat_q      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pend_stat_q <= '0;
      pend_dx_q   <= '0;
      pend_dy_q   <= '0;
      pend_q      <= 1'b0;
      dx9_q       <= '0;
      dyn_q       <= '0;
      x_q         <= 8'(X_MAX / 2);
      y_q         <= 7'(Y_MAX / 2);
      btn_q       <= '0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q   <= 1'b0;

      if (load_new) begin
        stat_q <= MOUSE_STATUS;
        dx_q   <= MOUSE_DX;
        dy_q   <= MOUSE_DY;
      end else if (load_pend) begin
        stat_q <= pend_stat_q;
        dx_q   <= pend_dx_q;
        dy_q   <= pend_dy_q;
      end

      // One-deep buffer: a later interrupt simply overwrites the held packet.
      if (hold_pend) begin
        pend_stat_q <= MOUSE_STATUS;
        pend_dx_q   <= MOUSE_DX;
        pend_dy_q   <= MOUSE_DY;
        pend_q      <= 1'b1;
      end else if (state_q == PUBLISH) begin
        pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (SEND_INTERRUPT) busy_q <= 1'b1;
        CALC: begin
          dx9_q <= dx9_d;
          dyn_q <= dyn_d;
        end
        APPLY: begin
          x_q   <= x_new;
          y_q   <= y_new;
          btn_q <= {stat_q[BTN_M], stat_q[BTN_R], stat_q[BTN_L]};
        end
        PUBLISH: begin
          upd_q  <= 1'b1;
          busy_q <= SEND_INTERRUPT || pend_q;
        end
        default: ;
      endcase
    end
  end

  assign MOUSE_X       = x_q;
  assign MOUSE_Y       = y_q;
  assign MOUSE_BUTTONS = btn_q;
  assign POS_UPDATED   = upd_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench for mouse_position_tracker: directed packets plus random
// packets compared against an arithmetic cursor model (honours MOUSE_SCROLL_EN).
module tb_mouse_position_tracker;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] MOUSE_STATUS = '0;
  logic [7:0] MOUSE_DX = '0;
  logic [7:0] MOUSE_DY = '0;
  logic [7:0] MOUSE_DZ = '0;
  logic       SEND_INTERRUPT = 1'b0;
  logic [7:0] MOUSE_X;
  logic [6:0] MOUSE_Y;
  logic [7:0] MOUSE_Z;
  logic [2:0] MOUSE_BUTTONS;
  logic       POS_UPDATED;
  logic       BUSY;

`ifdef MOUSE_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int mx, my, mz, mb;

  mouse_position_tracker dut (
    .CLK(CLK), .RESET(RESET),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY), .MOUSE_DZ(MOUSE_DZ),
    .SEND_INTERRUPT(SEND_INTERRUPT),
    .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_Z(MOUSE_Z),
    .MOUSE_BUTTONS(MOUSE_BUTTONS), .POS_UPDATED(POS_UPDATED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (POS_UPDATED === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] st, input logic [7:0] dx,
                      input logic [7:0] dy, input logic [7:0] dz);
    MOUSE_STATUS = st; MOUSE_DX = dx; MOUSE_DY = dy; MOUSE_DZ = dz;
    SEND_INTERRUPT = 1'b1;
    tick();
    SEND_INTERRUPT = 1'b0;
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(input logic [7:0] st, input int sgn, input int ovf,
                               input logic [7:0] mag);
    if (st[ovf]) return st[sgn] ? -256 : 255;
    return st[sgn] ? int'(mag) - 256 : int'(mag);
  endfunction

  task automatic model_reset();
    mx = 79; my = 59; mz = 0; mb = 0;
  endtask

  task automatic model_pkt(input logic [7:0] st, input logic [7:0] dx,
                           input logic [7:0] dy, input logic [7:0] dz);
    mx = clamp(mx + delta(st, 4, 6, dx), 159);
    my = clamp(my - delta(st, 5, 7, dy), 119);
    if (SCROLL) mz = clamp(mz + (int'(dz) >= 128 ? int'(dz) - 256 : int'(dz)), 255);
    mb = int'(st[2:0]);
  endtask

  task automatic do_reset();
    #1 RESET = 1'b0;
    #1 RESET = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic wait_pulses(input int base, input int n, input string tag);
    int k = 0;
    while (pulses - base < n && k < 30) begin
      tick();
      k++;
    end
    check(tag, pulses - base, n);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"}, int'(MOUSE_X), mx);
    check({tag, "_y"}, int'(MOUSE_Y), my);
    check({tag, "_z"}, int'(MOUSE_Z), mz);
    check({tag, "_btn"}, int'(MOUSE_BUTTONS), mb);
  endtask

  initial begin
    int p0;
    logic [7:0] st, dx, dy, dz;
    bit busy_ok;

    #2 RESET = 1'b0;
    #1;
    check("async_rst_x", int'(MOUSE_X), 79);
    check("async_rst_busy", int'(BUSY), 0);
    repeat (2) tick();
    RESET = 1'b1;
    model_reset();
    p0 = pulses;
    repeat (5) tick();
    check("idle_x", int'(MOUSE_X), 79);
    check("idle_y", int'(MOUSE_Y), 59);
    check("idle_z", int'(MOUSE_Z), 0);
    check("idle_btn", int'(MOUSE_BUTTONS), 0);
    check("idle_busy", int'(BUSY), 0);
    check("idle_no_pulse", pulses - p0, 0);

    // Basic packet with exact latency
    p0 = pulses;
    send(8'h01, 8'h0A, 8'h05, 8'h00);
    model_pkt(8'h01, 8'h0A, 8'h05, 8'h00);
    check("lat_busy_t", int'(BUSY), 1);
    tick();
    check("lat_x_t1", int'(MOUSE_X), 79);
    check("lat_upd_t1", int'(POS_UPDATED), 0);
    tick();
    check("lat_x_t2", int'(MOUSE_X), 89);
    check("lat_y_t2", int'(MOUSE_Y), 54);
    check("lat_btn_t2", int'(MOUSE_BUTTONS), 1);
    check("lat_upd_t2", int'(POS_UPDATED), 0);
    tick();
    check("lat_upd_t3", int'(POS_UPDATED), 1);
    check("lat_busy_t3", int'(BUSY), 0);
    tick();
    check("lat_upd_t4", int'(POS_UPDATED), 0);
    check("lat_pulses", pulses - p0, 1);
    check_model("basic");

    // Clamp low then overflow saturating high
    p0 = pulses;
    send(8'h10, 8'h00, 8'h00, 8'h00);
    model_pkt(8'h10, 8'h00, 8'h00, 8'h00);
    wait_pulses(p0, 1, "clamp_lo_pulse");
    check("clamp_lo_x", int'(MOUSE_X), 0);
    p0 = pulses;
    send(8'h40, 8'hFF, 8'h00, 8'h00);
    model_pkt(8'h40, 8'hFF, 8'h00, 8'h00);
    wait_pulses(p0, 1, "clamp_hi_pulse");
    check("clamp_hi_x", int'(MOUSE_X), 159);
    // Y overflow downwards and upwards
    p0 = pulses;
    send(8'hA0, 8'h00, 8'h00, 8'h00);
    model_pkt(8'hA0, 8'h00, 8'h00, 8'h00);
    wait_pulses(p0, 1, "clamp_ybot_pulse");
    check("clamp_ybot_y", int'(MOUSE_Y), 119);
    p0 = pulses;
    send(8'h80, 8'h00, 8'h00, 8'h00);
    model_pkt(8'h80, 8'h00, 8'h00, 8'h00);
    wait_pulses(p0, 1, "clamp_ytop_pulse");
    check("clamp_ytop_y", int'(MOUSE_Y), 0);
    check_model("clamp");

    // Two interrupts one cycle apart: both applied, BUSY held
    do_reset();
    p0 = pulses;
    send(8'h00, 8'h01, 8'h00, 8'h00);
    send(8'h00, 8'h02, 8'h00, 8'h00);
    busy_ok = 1'b1;
    repeat (4) begin
      tick();
      if (BUSY !== 1'b1) busy_ok = 1'b0;
    end
    check("b2b_busy_held", int'(busy_ok), 1);
    tick();
    check("b2b_upd_second", int'(POS_UPDATED), 1);
    check("b2b_x", int'(MOUSE_X), 82);
    tick();
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_busy_end", int'(BUSY), 0);

    // Three interrupts in one busy window: newest pending wins
    do_reset();
    p0 = pulses;
    send(8'h00, 8'h01, 8'h00, 8'h00);
    send(8'h00, 8'h02, 8'h00, 8'h00);
    send(8'h00, 8'h03, 8'h00, 8'h00);
    repeat (12) tick();
    check("tri_pulses", pulses - p0, 2);
    check("tri_x", int'(MOUSE_X), 83);

    // Interrupt landing in the PUBLISH cycle
    do_reset();
    p0 = pulses;
    send(8'h02, 8'h05, 8'h03, 8'h00);
    model_pkt(8'h02, 8'h05, 8'h03, 8'h00);
    tick();
    tick();
    send(8'h24, 8'h07, 8'h10, 8'h00);
    model_pkt(8'h24, 8'h07, 8'h10, 8'h00);
    wait_pulses(p0, 2, "pub_pulses");
    check_model("pub");

    // Reset mid-operation discards the in-flight packet
    p0 = pulses;
    send(8'h01, 8'h20, 8'h00, 8'h00);
    #2 RESET = 1'b0;
    #1;
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_x", int'(MOUSE_X), 79);
    RESET = 1'b1;
    model_reset();
    repeat (6) tick();
    check("midrst_no_pulse", pulses - p0, 0);
    check_model("midrst");

    // Scroll wheel
    p0 = pulses;
    send(8'h08, 8'h00, 8'h00, 8'hFF);
    model_pkt(8'h08, 8'h00, 8'h00, 8'hFF);
    wait_pulses(p0, 1, "z_neg_pulse");
    check("z_neg", int'(MOUSE_Z), 0);
    p0 = pulses;
    send(8'h08, 8'h00, 8'h00, 8'h03);
    model_pkt(8'h08, 8'h00, 8'h00, 8'h03);
    wait_pulses(p0, 1, "z_pos_pulse");
    check("z_pos", int'(MOUSE_Z), SCROLL ? 3 : 0);

    // Randomized packets against the model
    for (int i = 0; i < 60; i++) begin
      st = 8'($urandom);
      if ($urandom_range(0, 3) != 0) st[7:6] = 2'b00;
      dx = 8'($urandom);
      dy = 8'($urandom);
      dz = 8'($urandom);
      model_pkt(st, dx, dy, dz);
      p0 = pulses;
      send(st, dx, dy, dz);
      wait_pulses(p0, 1, "rnd_pulse");
      check_model("rnd");
      check("rnd_busy", int'(BUSY), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
